// File: rtl/cnn_ctrl_pkg.sv
// Shared definitions for the CNN window sequencers: controller state encoding,
// default geometry and the counter-width helper.
package cnn_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RUN,
    DRAIN
  } ctrl_state_e;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_KERNEL     = 3;
  localparam int unsigned DEF_COLS       = 8;
  localparam int unsigned DEF_ROWS       = 8;
  localparam int unsigned DEF_STRIDE     = 1;

  // clog2 with a floor of one bit so that degenerate sizes still get a port
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sr_pos_counter.sv
// Raster column/row position counter with exact wrap at COLS-1 / ROWS-1
// and last-column / last-row flags.
module sr_pos_counter
  import cnn_ctrl_pkg::*;
#(
  parameter int unsigned COLS = DEF_COLS,
  parameter int unsigned ROWS = DEF_ROWS,
  localparam int unsigned COL_W = cnt_w(COLS),
  localparam int unsigned ROW_W = cnt_w(ROWS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             advance,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             col_last,
  output logic             row_last
);

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;

  assign col      = col_q;
  assign row      = row_q;
  assign col_last = (col_q == COL_W'(COLS - 1));
  assign row_last = (row_q == ROW_W'(ROWS - 1));

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clear) begin
      col_d = '0;
      row_d = '0;
    end else if (advance) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

endmodule

// File: rtl/sr_window_ctrl.sv
// Sequencer for a KERNEL-deep parallel-out shift-register window fed by a raster stream.
// Optional column stride between emitted windows: define SR_CTRL_STRIDE_EN.
module sr_window_ctrl
  import cnn_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned KERNEL     = DEF_KERNEL,
  parameter int unsigned COLS       = DEF_COLS,
  parameter int unsigned ROWS       = DEF_ROWS,
  parameter int unsigned STRIDE     = DEF_STRIDE,
  localparam int unsigned COL_W = cnt_w(COLS),
  localparam int unsigned ROW_W = cnt_w(ROWS)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  sr_shift_en,
  output logic [DATA_WIDTH-1:0] sr_shift_in,
  output logic                  win_valid,
  input  logic                  win_ready,
  output logic [COL_W-1:0]      win_col,
  output logic [ROW_W-1:0]      win_row,
  output logic                  busy,
  output logic                  done
);

`ifdef SR_CTRL_STRIDE_EN
  localparam int unsigned STRIDE_EFF = (STRIDE < 1) ? 1 : STRIDE;
`else
  // STRIDE has no effect in this build; every RUN pixel emits
  localparam int unsigned STRIDE_EFF = STRIDE * 0 + 1;
`endif
  localparam int unsigned STR_W = cnt_w(STRIDE_EFF);
  localparam logic [COL_W-1:0] KM1 = COL_W'(KERNEL - 1);
  localparam logic [COL_W-1:0] KM2 = COL_W'(KERNEL - 2);

  ctrl_state_e      state_q, state_d;
  logic             win_valid_q, win_valid_d;
  logic [COL_W-1:0] win_col_q, win_col_d;
  logic [ROW_W-1:0] win_row_q, win_row_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [STR_W-1:0] stride_q, stride_d, stride_cur;

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             col_last, row_last;
  logic             accept, win_hs, emit;

  sr_pos_counter #(
    .COLS (COLS),
    .ROWS (ROWS)
  ) u_pos (
    .clock    (clock),
    .reset    (reset),
    .clear    (state_q == IDLE),
    .advance  (accept),
    .col      (col),
    .row      (row),
    .col_last (col_last),
    .row_last (row_last)
  );

  // Stall only while a window is held and not being consumed this cycle
  assign in_ready    = ((state_q == FILL) || (state_q == RUN)) && !(win_valid_q && !win_ready);
  assign accept      = in_valid && in_ready;
  assign win_hs      = win_valid_q && win_ready;
  assign sr_shift_en = accept;
  assign sr_shift_in = in_data;

  assign win_valid = win_valid_q;
  assign win_col   = win_col_q;
  assign win_row   = win_row_q;
  assign busy      = busy_q;
  assign done      = done_q;

  // First window of each row restarts the stride phase at zero
  always_comb begin
    stride_cur = (col == KM1) ? '0 : stride_q;
    emit       = (stride_cur == '0);
    stride_d   = stride_q;
    if (state_q == IDLE) begin
      stride_d = '0;
    end else if ((state_q == RUN) && accept) begin
      stride_d = (stride_cur == STR_W'(STRIDE_EFF - 1)) ? '0 : stride_cur + 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    win_valid_d = win_hs ? 1'b0 : win_valid_q;
    win_col_d   = win_col_q;
    win_row_d   = win_row_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FILL;
          busy_d  = 1'b1;
        end
      end
      FILL: begin
        if (accept && (col == KM2)) state_d = RUN;
      end
      RUN: begin
        if (accept) begin
          win_valid_d = emit;
          if (emit) begin
            win_col_d = col - KM1;
            win_row_d = row;
          end
          if (col_last) state_d = row_last ? DRAIN : FILL;
        end
      end
      DRAIN: begin
        if (!win_valid_q || win_ready) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      win_valid_q <= 1'b0;
      win_col_q   <= '0;
      win_row_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      stride_q    <= '0;
    end else begin
      state_q     <= state_d;
      win_valid_q <= win_valid_d;
      win_col_q   <= win_col_d;
      win_row_q   <= win_row_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      stride_q    <= stride_d;
    end
  end

endmodule
